// File: rtl/writeback_port_arbiter.sv
// Shares the single register-file write port between the in-order pipeline
// writeback and a FIFO-buffered auxiliary result source.
module writeback_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pipe_write,
  input  logic [4:0]                    pipe_reg,
  input  logic [DATA_WIDTH-1:0]         pipe_data,
  input  logic                          aux_valid,
  output logic                          aux_ready,
  input  logic [4:0]                    aux_reg,
  input  logic [DATA_WIDTH-1:0]         aux_data,
  output logic                          stall_pipe,
  output logic                          rf_write,
  output logic [4:0]                    rf_reg,
  output logic [DATA_WIDTH-1:0]         rf_data,
  output logic [$clog2(FIFO_DEPTH):0]   aux_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STEAL = 2'd2
  } state_t;

  state_t                  state, next_state;
  logic [4:0]              fifo_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count, count_next;
  logic [WAIT_W-1:0]       wait_cnt, wait_next;

  logic pipe_active;
  logic enq, deq;
  logic grant_pipe;

  assign pipe_active = pipe_write && (pipe_reg != 5'd0);
  assign aux_ready   = (count < CNT_W'(FIFO_DEPTH));
  // Writes aimed at x0 are accepted from the aux source but never stored.
  assign enq         = aux_valid && aux_ready && (aux_reg != 5'd0);
  assign stall_pipe  = (state == STEAL);
  assign aux_count   = count;

  always_comb begin
    case ({enq, deq})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    next_state = state;
    wait_next  = wait_cnt;
    deq        = 1'b0;
    grant_pipe = 1'b0;
    case (state)
      IDLE: begin
        grant_pipe = pipe_active;
        if (count_next != '0) next_state = PEND;
      end
      PEND: begin
        if (!pipe_active) begin
          deq        = 1'b1;
          wait_next  = '0;
          next_state = (count_next == '0) ? IDLE : PEND;
        end else begin
          grant_pipe = 1'b1;
          wait_next  = wait_cnt + WAIT_W'(1);
          if (wait_next == WAIT_W'(MAX_WAIT)) next_state = STEAL;
        end
      end
      STEAL: begin
        deq        = 1'b1;
        wait_next  = '0;
        next_state = (count_next == '0) ? IDLE : PEND;
      end
      default: begin
        next_state = IDLE;
        wait_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_reg[wr_ptr]  <= aux_reg;
      fifo_data[wr_ptr] <= aux_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_reg   <= '0;
      rf_data  <= '0;
    end else if (grant_pipe) begin
      rf_write <= 1'b1;
      rf_reg   <= pipe_reg;
      rf_data  <= pipe_data;
    end else if (deq) begin
      rf_write <= 1'b1;
      rf_reg   <= fifo_reg[rd_ptr];
      rf_data  <= fifo_data[rd_ptr];
    end else begin
      rf_write <= 1'b0;
      rf_reg   <= '0;
      rf_data  <= '0;
    end
  end

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Randomized and directed bench for writeback_port_arbiter, checked against a
// queue-based model of the write-port sharing rules.
module tb_writeback_port_arbiter;

  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_WAIT   = 4;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        pipe_write = 1'b0;
  logic [4:0]                  pipe_reg = '0;
  logic [DATA_WIDTH-1:0]       pipe_data = '0;
  logic                        aux_valid = 1'b0;
  logic                        aux_ready;
  logic [4:0]                  aux_reg = '0;
  logic [DATA_WIDTH-1:0]       aux_data = '0;
  logic                        stall_pipe;
  logic                        rf_write;
  logic [4:0]                  rf_reg;
  logic [DATA_WIDTH-1:0]       rf_data;
  logic [$clog2(FIFO_DEPTH):0] aux_count;

  writeback_port_arbiter #(
    .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .pipe_write(pipe_write), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_reg(aux_reg), .aux_data(aux_data),
    .stall_pipe(stall_pipe), .rf_write(rf_write), .rf_reg(rf_reg),
    .rf_data(rf_data), .aux_count(aux_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending aux results, lost-arbitration tally, steal flag.
  bit [4:0]  q_reg[$];
  bit [31:0] q_data[$];
  int        m_wait;
  bit        m_steal;
  bit        exp_write;
  bit [4:0]  exp_reg;
  bit [31:0] exp_data;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    q_reg.delete();
    q_data.delete();
    m_wait = 0;
    m_steal = 0;
    exp_write = 0;
    exp_reg = 0;
    exp_data = 0;
  endtask

  task automatic checkState();
    checkOutput("stall_pipe", 32'(stall_pipe), 32'(m_steal));
    checkOutput("aux_ready", 32'(aux_ready), 32'(q_reg.size() < FIFO_DEPTH));
    checkOutput("aux_count", 32'(aux_count), 32'(q_reg.size()));
    checkOutput("rf_write", 32'(rf_write), 32'(exp_write));
    if (exp_write) begin
      checkOutput("rf_reg", 32'(rf_reg), 32'(exp_reg));
      checkOutput("rf_data", rf_data, exp_data);
    end
  endtask

  // Drives one cycle of inputs, checks the DUT against the model at the
  // falling edge, then advances the model across the rising edge.
  task automatic applyStimulus(input bit pw, input bit [4:0] preg, input bit [31:0] pdata,
                               input bit av, input bit [4:0] areg, input bit [31:0] adata);
    bit pipe_act, accept;
    pipe_write = pw;  pipe_reg = preg;  pipe_data = pdata;
    aux_valid = av;   aux_reg = areg;   aux_data = adata;
    @(negedge clock);
    checkState();
    pipe_act = pw && (preg != 0);
    accept   = av && (q_reg.size() < FIFO_DEPTH);
    exp_write = 0;
    if (m_steal) begin
      exp_write = 1; exp_reg = q_reg.pop_front(); exp_data = q_data.pop_front();
      m_wait = 0; m_steal = 0;
    end else if (q_reg.size() == 0) begin
      if (pipe_act) begin exp_write = 1; exp_reg = preg; exp_data = pdata; end
    end else if (!pipe_act) begin
      exp_write = 1; exp_reg = q_reg.pop_front(); exp_data = q_data.pop_front();
      m_wait = 0;
    end else begin
      exp_write = 1; exp_reg = preg; exp_data = pdata;
      m_wait++;
      if (m_wait == MAX_WAIT) begin m_steal = 1; m_wait = 0; end
    end
    if (accept && areg != 0) begin
      q_reg.push_back(areg);
      q_data.push_back(adata);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    pipe_write = 0; aux_valid = 0;
    reset = 1'b1;
    #2;
    checkOutput("reset stall_pipe", 32'(stall_pipe), 32'd0);
    checkOutput("reset rf_write", 32'(rf_write), 32'd0);
    checkOutput("reset aux_count", 32'(aux_count), 32'd0);
    checkOutput("reset aux_ready", 32'(aux_ready), 32'd1);
    modelClear();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int guard;
    modelClear();
    @(posedge clock);
    #1;
    doReset();

    // Plain pipeline write with empty FIFO
    applyStimulus(1, 5'd5, 32'hAA, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // Single aux push drained while pipe idle
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Three aux offers against a continuously active pipe: fill, steal, re-steal
    applyStimulus(1, 5'd1, 32'h100, 1, 5'd9, 32'h1);
    applyStimulus(1, 5'd2, 32'h101, 1, 5'd10, 32'h2);
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 5'(1 + (i % 2)), 32'h200 + 32'(i), 1, 5'd11, 32'h3);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 5'd3, 32'h300 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // x0 writes from both sources
    applyStimulus(1, 5'd4, 32'h44, 1, 5'd12, 32'h55);
    applyStimulus(1, 5'd0, 32'h66, 1, 5'd0, 32'h77);
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h88);
    applyStimulus(1, 5'd0, 32'h99, 0, 0, 0);

    // Reset during a steal slot with entries still queued
    doReset();
    applyStimulus(1, 5'd6, 32'hA0, 1, 5'd13, 32'hB0);
    applyStimulus(1, 5'd6, 32'hA1, 1, 5'd14, 32'hB1);
    guard = 0;
    while (!m_steal && guard < 20) begin
      applyStimulus(1, 5'd6, 32'hA2, 1, 5'd15, 32'hB2);
      guard++;
    end
    checkOutput("steal reached", 32'(m_steal), 32'd1);
    checkOutput("steal stall_pipe", 32'(stall_pipe), 32'd1);
    checkOutput("steal queue depth", 32'(aux_count), 32'd2);
    doReset();
    checkOutput("post-reset stall_pipe", 32'(stall_pipe), 32'd0);
    checkOutput("post-reset aux_ready", 32'(aux_ready), 32'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      bit pw, av;
      bit [4:0] preg, areg;
      pw   = ($urandom_range(0, 3) != 0);
      av   = ($urandom_range(0, 1) != 0);
      preg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      areg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 199) == 0) doReset();
      else applyStimulus(pw, preg, $urandom, av, areg, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_port_arbiter.md
Name: writeback_port_arbiter

Overview:
- Shares the single register-file write port between two sources.
- Source 1 is the in-order pipeline writeback (write/reg/data from the writeback stage). Source 2 is an auxiliary source for late results, such as a multi-cycle unit or late load return.
- Aux results are buffered in a small in-order FIFO. Pipeline writes have priority; a wait counter bounds aux starvation by stalling the pipeline for one slot.

Parameters:
- DATA_WIDTH, 32, width of write data.
- FIFO_DEPTH, 2, aux FIFO entries; power of two, >= 2.
- MAX_WAIT, 4, consecutive lost arbitration cycles for a non-empty FIFO before a steal slot is forced; >= 1.

Ports:
- clock  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pipe_write  input  1  writeback stage requests a register write this cycle.
- pipe_reg  input  5  destination register of the pipeline write.
- pipe_data  input  DATA_WIDTH  pipeline write data.
- aux_valid  input  1  aux source offers a result.
- aux_ready  output  1  FIFO can accept; transfer occurs when aux_valid & aux_ready.
- aux_reg  input  5  aux destination register.
- aux_data  input  DATA_WIDTH  aux result data.
- stall_pipe  output  1  pipeline must freeze; its write is not taken this cycle.
- rf_write  output  1  register-file write enable.
- rf_reg  output  5  register-file write address.
- rf_data  output  DATA_WIDTH  register-file write data.
- aux_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous: FIFO emptied, pointers = 0, wait_cnt = 0, state = IDLE. All outputs are 0 except aux_ready = 1.
- aux_ready = (aux_count < FIFO_DEPTH).
  - Depends on occupancy only: no enqueue when full, even if a dequeue happens the same cycle.
  - An accepted aux write with aux_reg == 0 is consumed and discarded (not enqueued).
- No bypass: an entry enqueued in cycle N is eligible for grant from cycle N+1.
- rf_write / rf_reg / rf_data are registered: a grant in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
- Writes to x0 from either source never produce rf_write = 1.
- "pipe active" = pipe_write & (pipe_reg != 0).
- States:
  - IDLE: FIFO empty, stall_pipe = 0, pipe active is granted.
    - Goes to PEND when the FIFO becomes non-empty.
  - PEND: FIFO non-empty, stall_pipe = 0.
    - If pipe not active: FIFO head granted and dequeued; wait_cnt = 0. Next state is IDLE if FIFO becomes empty, else PEND.
    - If pipe active: pipe granted and wait_cnt++.
    - If wait_cnt reaches MAX_WAIT on that increment: next state STEAL.
  - STEAL: stall_pipe = 1, driven directly from state.
    - Head granted and dequeued; pipe_write ignored (pipeline is frozen and re-presents its write next cycle); wait_cnt = 0.
    - Next state is PEND if FIFO still non-empty, else IDLE.
    - Lasts exactly one cycle.
- Simultaneous aux enqueue and head dequeue: both take effect; aux_count is unchanged.
- Pointer wrap-around is modulo FIFO_DEPTH.
- FIFO order is strict; no reordering.
- WAW ordering between the two sources is the issue logic's responsibility; the arbiter performs no register comparisons.
- Reset asserted mid-operation (including in STEAL): all FIFO contents are lost and outputs clear immediately.

Test Plan:
1. Reset, then pipe_write=1, pipe_reg=5, pipe_data=0xAA, FIFO empty -> next cycle rf_write=1, rf_reg=5, rf_data=0xAA; stall_pipe=0; aux_ready=1.
2. Aux push reg=7, data=0x11 while pipe idle -> aux_count=1. Next cycle head granted; the cycle after, rf_reg=7, rf_data=0x11; aux_count returns to 0.
3. FIFO_DEPTH=2, push 3 aux entries with pipe continuously active (regs 1,2) -> third held (aux_ready=0 with aux_count=2). After MAX_WAIT=4 pipe wins, stall_pipe=1 for exactly 1 cycle and aux entry 1 is written. Re-stall occurs after another 4 pipe wins.
4. Full FIFO: aux_valid=1 in the same cycle as a dequeue -> not accepted (aux_ready=0); accepted the following cycle; data order preserved (0x1, 0x2, 0x3).
5. Pipe write reg 0 with FIFO non-empty -> aux head granted that cycle; no rf_write for x0. Aux push to reg 0 -> aux_count unchanged, no rf_write ever.
6. Reset asserted during STEAL with 2 entries queued -> stall_pipe, rf_write, aux_count = 0 immediately. After release, state IDLE and aux_ready=1.
